// File: rtl/line_stream_bridge.sv
// Bridges line-wide memory requests/responses onto a beat-wide request/response stream pair.
// Optional response checking is enabled by defining LINE_STREAM_BRIDGE_RESP_CHECK_EN.
module line_stream_bridge #(
    parameter int LINE_W          = 512,
    parameter int BEAT_W          = 128,
    parameter int ADDR_W          = 26,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    output logic                         getMReq_en,
    input  logic                         getMReq_rdy,
    input  logic [ADDR_W+LINE_W:0]       getMReq_data,
    output logic                         putMResp_en,
    input  logic                         putMResp_rdy,
    output logic [LINE_W-1:0]            putMResp_data,
    output logic [BEAT_W-1:0]            req_axis_data,
    output logic                         req_axis_tuser,
    output logic                         req_axis_valid,
    input  logic                         req_axis_ready,
    input  logic [BEAT_W-1:0]            resp_axis_data,
    input  logic                         resp_axis_tuser,
    input  logic                         resp_axis_valid,
    output logic                         resp_axis_ready,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                         resp_err
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int IDX_W = $clog2(BEATS);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int HDR_W = 55;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_line;
    logic [IDX_W-1:0]  req_idx;

    logic [IDX_W-1:0]  rsp_idx;
    logic [LINE_W-1:0] rsp_line;
    logic              line_full;
    logic [OUT_W-1:0]  out_cnt;

    logic              can_issue;
    logic              hdr_fire;
    logic              data_fire;
    logic              rd_issue;
    logic              rsp_fire;
    logic [26:0]       hdr_addr;
    logic [26:0]       hdr_len;
    logic [BEAT_W-1:0] hdr_beat;

    // Header carries the beat-granular address and the fixed line length in beats.
    assign hdr_addr = 27'(req_addr) << IDX_W;
    assign hdr_len  = 27'(BEATS);
    assign hdr_beat = BEAT_W'({hdr_addr, hdr_len, req_write});

    assign can_issue = (out_cnt < OUT_W'(MAX_OUTSTANDING));
    assign hdr_fire  = (state == HDR) && req_axis_ready;
    assign data_fire = (state == DATA) && req_axis_ready;
    assign rd_issue  = hdr_fire && !req_write;

    always_comb begin
        state_next     = state;
        getMReq_en     = 1'b0;
        req_axis_valid = 1'b0;
        req_axis_tuser = 1'b0;
        req_axis_data  = '0;
        case (state)
            IDLE: begin
                getMReq_en = getMReq_rdy && can_issue;
                if (getMReq_en) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                req_axis_valid = 1'b1;
                req_axis_tuser = 1'b1;
                req_axis_data  = hdr_beat;
                if (req_axis_ready) begin
                    state_next = req_write ? DATA : IDLE;
                end
            end
            DATA: begin
                req_axis_valid = 1'b1;
                req_axis_data  = req_line[req_idx*BEAT_W +: BEAT_W];
                if (req_axis_ready && (req_idx == IDX_W'(BEATS - 1))) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            req_write <= 1'b0;
            req_addr  <= '0;
            req_line  <= '0;
            req_idx   <= '0;
        end else begin
            if (getMReq_en) begin
                {req_write, req_addr, req_line} <= getMReq_data;
            end
            if (hdr_fire) begin
                req_idx <= '0;
            end else if (data_fire) begin
                req_idx <= req_idx + 1'b1;
            end
        end
    end

    // A full line blocks further beats until it is handed off, giving one bubble per line.
    assign resp_axis_ready = !line_full;
    assign rsp_fire        = resp_axis_valid && !line_full;
    assign putMResp_en     = line_full && putMResp_rdy;
    assign putMResp_data   = rsp_line;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rsp_idx   <= '0;
            rsp_line  <= '0;
            line_full <= 1'b0;
        end else begin
            if (rsp_fire) begin
                rsp_line[rsp_idx*BEAT_W +: BEAT_W] <= resp_axis_data;
                rsp_idx <= rsp_idx + 1'b1;
                if (rsp_idx == IDX_W'(BEATS - 1)) begin
                    line_full <= 1'b1;
                end
            end else if (putMResp_en) begin
                line_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_cnt <= '0;
        end else begin
            case ({rd_issue, putMResp_en})
                2'b10: if (out_cnt < OUT_W'(MAX_OUTSTANDING)) out_cnt <= out_cnt + 1'b1;
                2'b01: if (out_cnt != '0) out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    assign outstanding = out_cnt;

`ifdef LINE_STREAM_BRIDGE_RESP_CHECK_EN
    logic err_q;

    // Flags a header-marked response beat, or a line starting with nothing in flight.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            err_q <= 1'b0;
        end else if (rsp_fire && (resp_axis_tuser || ((rsp_idx == '0) && (out_cnt == '0)))) begin
            err_q <= 1'b1;
        end
    end

    assign resp_err = err_q;
`else
    logic unused_tuser;

    assign unused_tuser = resp_axis_tuser;
    assign resp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_line_stream_bridge.sv
// Directed bench for line_stream_bridge: queue-based behavioural model checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_line_stream_bridge;

    localparam int LINE_W  = 512;
    localparam int BEAT_W  = 128;
    localparam int ADDR_W  = 26;
    localparam int MAX_OUT = 4;
    localparam int BEATS   = 4;
    localparam int OUT_W   = 3;

    logic                   clk;
    logic                   rst_in;
    logic                   getMReq_en;
    logic                   getMReq_rdy;
    logic [ADDR_W+LINE_W:0] getMReq_data;
    logic                   putMResp_en;
    logic                   putMResp_rdy;
    logic [LINE_W-1:0]      putMResp_data;
    logic [BEAT_W-1:0]      req_axis_data;
    logic                   req_axis_tuser;
    logic                   req_axis_valid;
    logic                   req_axis_ready;
    logic [BEAT_W-1:0]      resp_axis_data;
    logic                   resp_axis_tuser;
    logic                   resp_axis_valid;
    logic                   resp_axis_ready;
    logic [OUT_W-1:0]       outstanding;
    logic                   resp_err;

    line_stream_bridge #(
        .LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk_in(clk), .rst_in(rst_in),
        .getMReq_en(getMReq_en), .getMReq_rdy(getMReq_rdy), .getMReq_data(getMReq_data),
        .putMResp_en(putMResp_en), .putMResp_rdy(putMResp_rdy), .putMResp_data(putMResp_data),
        .req_axis_data(req_axis_data), .req_axis_tuser(req_axis_tuser),
        .req_axis_valid(req_axis_valid), .req_axis_ready(req_axis_ready),
        .resp_axis_data(resp_axis_data), .resp_axis_tuser(resp_axis_tuser),
        .resp_axis_valid(resp_axis_valid), .resp_axis_ready(resp_axis_ready),
        .outstanding(outstanding), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BEAT_W-1:0] data;
        bit                hdr;
        bit                rd;
    } beat_t;

    beat_t             pend[$];
    logic [BEAT_W-1:0] seen_req[$];
    logic [LINE_W-1:0] seen_line[$];
    logic [BEAT_W-1:0] m_line[BEATS];
    int                m_out;
    int                m_cnt;
    bit                m_full;
    bit                m_err;
    bit                req_acc;
    bit                resp_acc;
    int                checks;
    int                errors;

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out", nm);
    endtask

    // Model: pending request beats in a queue, response beats gathered into a line slot.
    task automatic model_step();
        bit                e_en, e_valid, e_tuser, e_rdy, e_pen, inc, dec;
        logic [BEAT_W-1:0] e_data;
        logic [LINE_W-1:0] e_line;
        longint            hdr;
        beat_t             b;
        e_valid = (pend.size() > 0);
        e_tuser = 1'b0;
        e_data  = '0;
        if (e_valid) begin
            e_tuser = pend[0].hdr;
            e_data  = pend[0].data;
        end
        e_en  = getMReq_rdy && !e_valid && (m_out < MAX_OUT);
        e_rdy = !m_full;
        e_pen = m_full && putMResp_rdy;
        for (int k = 0; k < BEATS; k++) e_line[k*BEAT_W +: BEAT_W] = m_line[k];

        chk("getMReq_en", LINE_W'(getMReq_en), LINE_W'(e_en));
        chk("req_valid", LINE_W'(req_axis_valid), LINE_W'(e_valid));
        chk("req_tuser", LINE_W'(req_axis_tuser), LINE_W'(e_tuser));
        chk("req_data", LINE_W'(req_axis_data), LINE_W'(e_data));
        chk("resp_ready", LINE_W'(resp_axis_ready), LINE_W'(e_rdy));
        chk("putMResp_en", LINE_W'(putMResp_en), LINE_W'(e_pen));
        chk("outstanding", LINE_W'(outstanding), LINE_W'(m_out));
        chk("resp_err", LINE_W'(resp_err), LINE_W'(m_err));
        if (e_pen) chk("putMResp_data", putMResp_data, e_line);

        if (rst_in) begin
            pend.delete();
            m_out  = 0;
            m_cnt  = 0;
            m_full = 1'b0;
            m_err  = 1'b0;
            return;
        end
        inc = 1'b0;
        dec = 1'b0;
        if (e_valid && req_axis_ready) begin
            seen_req.push_back(req_axis_data);
            if (pend[0].hdr && pend[0].rd) inc = 1'b1;
            void'(pend.pop_front());
        end
        if (e_pen) begin
            seen_line.push_back(putMResp_data);
            m_full = 1'b0;
            dec    = 1'b1;
        end
        if (resp_axis_valid && e_rdy) begin
`ifdef LINE_STREAM_BRIDGE_RESP_CHECK_EN
            if (resp_axis_tuser || (m_cnt == 0 && m_out == 0)) m_err = 1'b1;
`endif
            m_line[m_cnt] = resp_axis_data;
            m_cnt++;
            if (m_cnt == BEATS) begin
                m_cnt  = 0;
                m_full = 1'b1;
            end
            resp_acc = 1'b1;
        end
        if (inc && !dec) m_out++;
        else if (dec && !inc && m_out > 0) m_out--;
        if (e_en) begin
            hdr = ((longint'(getMReq_data[LINE_W +: ADDR_W]) * BEATS) << 28)
                | (longint'(BEATS) << 1) | longint'(getMReq_data[ADDR_W+LINE_W]);
            b.data = BEAT_W'(hdr);
            b.hdr  = 1'b1;
            b.rd   = !getMReq_data[ADDR_W+LINE_W];
            pend.push_back(b);
            if (getMReq_data[ADDR_W+LINE_W]) begin
                for (int k = 0; k < BEATS; k++) begin
                    b.data = getMReq_data[k*BEAT_W +: BEAT_W];
                    b.hdr  = 1'b0;
                    b.rd   = 1'b0;
                    pend.push_back(b);
                end
            end
            req_acc = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] ln);
        getMReq_data = {wr, a, ln};
        getMReq_rdy  = 1'b1;
        req_acc      = 1'b0;
        for (int i = 0; i < 60 && !req_acc; i++) tick();
        getMReq_rdy = 1'b0;
        if (!req_acc) timeout("req_accept");
    endtask

    task automatic wait_idle(input bit toggle);
        for (int i = 0; i < 60 && pend.size() > 0; i++) begin
            if (toggle) req_axis_ready = ~req_axis_ready;
            tick();
        end
        req_axis_ready = 1'b1;
        if (pend.size() > 0) timeout("req_drain");
    endtask

    task automatic send_resp(input logic [BEAT_W-1:0] d, input bit tu);
        resp_axis_data  = d;
        resp_axis_tuser = tu;
        resp_axis_valid = 1'b1;
        resp_acc        = 1'b0;
        for (int i = 0; i < 60 && !resp_acc; i++) tick();
        resp_axis_valid = 1'b0;
        resp_axis_tuser = 1'b0;
        if (!resp_acc) timeout("resp_accept");
    endtask

    task automatic wait_lines(input int n);
        for (int i = 0; i < 60 && seen_line.size() < n; i++) tick();
        if (seen_line.size() < n) timeout("line_deliver");
    endtask

    task automatic pulse_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        tick();
    endtask

    initial begin
        logic [BEAT_W-1:0] t;
        logic [LINE_W-1:0] wl;
        int                base;
        bit                exp_err;
        checks = 0;
        errors = 0;
        m_out = 0; m_cnt = 0; m_full = 1'b0; m_err = 1'b0;
        for (int k = 0; k < BEATS; k++) m_line[k] = '0;
        rst_in = 1'b1;
        getMReq_rdy = 1'b0; getMReq_data = '0;
        putMResp_rdy = 1'b0; req_axis_ready = 1'b0;
        resp_axis_data = '0; resp_axis_tuser = 1'b0; resp_axis_valid = 1'b0;
        repeat (3) tick();
        rst_in = 1'b0;
        tick();
        chk("reset_outstanding", LINE_W'(outstanding), LINE_W'(0));
        chk("reset_req_valid", LINE_W'(req_axis_valid), LINE_W'(0));
        chk("reset_putMResp_en", LINE_W'(putMResp_en), LINE_W'(0));

        // Single read header.
        req_axis_ready = 1'b1;
        base = seen_req.size();
        do_req(1'b0, 26'h10, '0);
        wait_idle(1'b0);
        tick();
        t = seen_req[base];
        chk("read_hdr", LINE_W'(t[54:0]), LINE_W'(55'h4_0000_0008));
        chk("read_outstanding", LINE_W'(outstanding), LINE_W'(1));

        // Write with a stalling consumer.
        for (int i = 0; i < 16; i++) wl[i*32 +: 32] = 32'(i);
        base = seen_req.size();
        do_req(1'b1, 26'h3, wl);
        wait_idle(1'b1);
        tick();
        chk("write_beats", LINE_W'(seen_req.size() - base), LINE_W'(5));
        t = seen_req[base];
        chk("write_hdr", LINE_W'(t[54:0]), LINE_W'(55'h0_C000_0009));
        t = seen_req[base+1];
        chk("write_beat0", LINE_W'(t[31:0]), LINE_W'(0));
        t = seen_req[base+4];
        chk("write_beat3", LINE_W'(t[127:96]), LINE_W'(15));

        // Fill up to the outstanding limit.
        for (int a = 1; a <= 3; a++) begin
            do_req(1'b0, 26'(a), '0);
            wait_idle(1'b0);
        end
        chk("full_outstanding", LINE_W'(outstanding), LINE_W'(4));
        getMReq_data = {1'b0, 26'h9, {LINE_W{1'b0}}};
        getMReq_rdy  = 1'b1;
        req_acc      = 1'b0;
        repeat (4) tick();
        chk("full_en_low", LINE_W'(getMReq_en), LINE_W'(0));

        // Held line, then delivered; the stalled read goes out after.
        putMResp_rdy = 1'b0;
        send_resp(128'hA, 1'b0);
        send_resp(128'hB, 1'b0);
        send_resp(128'hC, 1'b0);
        send_resp(128'hD, 1'b0);
        repeat (3) tick();
        chk("held_resp_ready", LINE_W'(resp_axis_ready), LINE_W'(0));
        chk("held_putMResp_en", LINE_W'(putMResp_en), LINE_W'(0));
        putMResp_rdy = 1'b1;
        wait_lines(1);
        for (int i = 0; i < 20 && !req_acc; i++) tick();
        getMReq_rdy = 1'b0;
        if (!req_acc) timeout("reissue");
        chk("line_dcba", seen_line[0], {128'hD, 128'hC, 128'hB, 128'hA});
        wait_idle(1'b0);

        // Drain the four in-flight reads back to back.
        for (int l = 0; l < 4; l++)
            for (int k = 0; k < BEATS; k++) send_resp(BEAT_W'(l*16 + k), 1'b0);
        wait_lines(5);
        repeat (2) tick();
        chk("drain_outstanding", LINE_W'(outstanding), LINE_W'(0));
        t = seen_line[4][BEAT_W +: BEAT_W];
        chk("drain_last_beat1", LINE_W'(t), LINE_W'(49));

        // Reset in the middle of a write.
        base = seen_req.size();
        do_req(1'b1, 26'h5, wl);
        for (int i = 0; i < 20 && seen_req.size() < base + 3; i++) tick();
        req_axis_ready = 1'b0;
        pulse_reset();
        req_axis_ready = 1'b1;
        repeat (4) tick();
        chk("abort_beats", LINE_W'(seen_req.size() - base), LINE_W'(3));
        chk("abort_outstanding", LINE_W'(outstanding), LINE_W'(0));
        base = seen_req.size();
        do_req(1'b0, 26'h7, '0);
        wait_idle(1'b0);
        t = seen_req[base];
        chk("post_reset_hdr", LINE_W'(t[54:0]), LINE_W'(55'h1_C000_0008));

        // Response beat carrying tuser.
`ifdef LINE_STREAM_BRIDGE_RESP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        send_resp(128'h55, 1'b1);
        tick();
        chk("tuser_err", LINE_W'(resp_err), LINE_W'(exp_err));
        repeat (3) tick();
        chk("tuser_err_hold", LINE_W'(resp_err), LINE_W'(exp_err));
        pulse_reset();
        chk("err_cleared", LINE_W'(resp_err), LINE_W'(0));

        // Unsolicited line with nothing in flight: count must not underflow.
        putMResp_rdy = 1'b1;
        for (int k = 0; k < BEATS; k++) send_resp(BEAT_W'(k + 100), 1'b0);
        wait_lines(6);
        repeat (2) tick();
        chk("no_underflow", LINE_W'(outstanding), LINE_W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
